// File: rtl/request_conditioner_pkg.sv
// Shared phase codes and the mapping from phase to the request bits it serves.
// Every block that decodes the controller phase imports this package.
package request_conditioner_pkg;

    typedef enum logic [1:0] {
        PHASE_STRAIGHT      = 2'd0,
        PHASE_STRAIGHT_TURN = 2'd1,
        PHASE_CROSS         = 2'd2,
        PHASE_CROSS_TURN    = 2'd3
    } phase_t;

    localparam phase_t PED_STRAIGHT_PHASE = PHASE_STRAIGHT;
    localparam phase_t PED_CROSS_PHASE    = PHASE_CROSS;

    function automatic logic [1:0] ped_served_mask(input logic [1:0] phase);
        logic [1:0] mask;
        mask    = 2'b00;
        mask[0] = (phase == PED_STRAIGHT_PHASE);
        mask[1] = (phase == PED_CROSS_PHASE);
        return mask;
    endfunction

    // Car lanes are indexed directly by phase code.
    function automatic logic [3:0] car_served_mask(input logic [1:0] phase);
        return 4'b0001 << phase;
    endfunction

endpackage

// File: rtl/request_conditioner_debouncer.sv
// Two-flop synchroniser followed by a stability counter; the clean level only
// follows the synchronised input after it disagrees for DEBOUNCE_CYCLES cycles.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_out;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
        end
    end

    // The edge that would bring the count to DEBOUNCE_CYCLES flips the level instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            clean <= 1'b0;
        end else if (sync_out == clean) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            count <= '0;
            clean <= sync_out;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/request_conditioner.sv
// Debounces the pedestrian buttons and car sensors and latches them as sticky
// requests that clear while the controller serves the matching phase.
module request_conditioner
    import request_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int SENSOR_DWELL    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] ped_button,
    input  logic [3:0] car_sensor,
    input  logic [1:0] phase,
    output logic [1:0] ped_request,
    output logic [3:0] car_request,
    output logic       any_request
);

    localparam int DWELL_W = $clog2(SENSOR_DWELL + 1);
    localparam logic [DWELL_W-1:0] DWELL_FULL = DWELL_W'(SENSOR_DWELL);

    logic [1:0]         ped_level;
    logic [1:0]         ped_level_q;
    logic [3:0]         car_level;
    logic [DWELL_W-1:0] dwell_q [4];
    logic [DWELL_W-1:0] dwell_d [4];
    logic [1:0]         ped_served;
    logic [3:0]         car_served;
    logic [3:0]         car_set;
    logic [1:0]         ped_req_d;
    logic [3:0]         car_req_d;
    logic               any_d;

    for (genvar g = 0; g < 2; g++) begin : g_ped_db
        input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (ped_button[g]),
            .clean (ped_level[g])
        );
    end

    for (genvar g = 0; g < 4; g++) begin : g_car_db
        input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (car_sensor[g]),
            .clean (car_level[g])
        );
    end

    // Dwell restarts while a lane is served, so a sensor still high afterwards
    // must dwell again before re-requesting.
    always_comb begin
        ped_served = ped_served_mask(phase);
        car_served = car_served_mask(phase);
        car_set    = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            dwell_d[i] = '0;
            if (car_level[i] && !car_served[i]) begin
                dwell_d[i] = (dwell_q[i] == DWELL_FULL) ? dwell_q[i] : dwell_q[i] + DWELL_W'(1);
            end
            car_set[i] = (dwell_d[i] == DWELL_FULL);
        end
        ped_req_d = (ped_request | (ped_level & ~ped_level_q)) & ~ped_served;
        car_req_d = (car_request | car_set) & ~car_served;
        any_d     = (|(ped_req_d & ~ped_served)) | (|(car_req_d & ~car_served));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_level_q <= 2'b00;
            ped_request <= 2'b00;
            car_request <= 4'b0000;
            any_request <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                dwell_q[i] <= '0;
            end
        end else begin
            ped_level_q <= ped_level;
            ped_request <= ped_req_d;
            car_request <= car_req_d;
            any_request <= any_d;
            for (int i = 0; i < 4; i++) begin
                dwell_q[i] <= dwell_d[i];
            end
        end
    end

endmodule

// File: tb/tb_request_conditioner.sv
// Scoreboard bench for request_conditioner: each stimulus step queues the
// outputs expected at a given cycle, and a negedge monitor checks them.
module tb_request_conditioner;

    logic       clk;
    logic       rst_n;
    logic [1:0] ped_button;
    logic [3:0] car_sensor;
    logic [1:0] phase;
    logic [1:0] ped_request;
    logic [3:0] car_request;
    logic       any_request;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    typedef struct {
        int         at;
        string      tag;
        logic [1:0] ped;
        logic [3:0] car;
        logic       any_req;
    } expect_t;

    expect_t sb[$];

    request_conditioner #(.DEBOUNCE_CYCLES(20), .SENSOR_DWELL(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ped_button  (ped_button),
        .car_sensor  (car_sensor),
        .phase       (phase),
        .ped_request (ped_request),
        .car_request (car_request),
        .any_request (any_request)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle index; stimulus offsets are measured against it.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] btn, input logic [3:0] sens, input logic [1:0] ph);
        ped_button = btn;
        car_sensor = sens;
        phase      = ph;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue the outputs expected after the edge 'offset' cycles from now, kept sorted by cycle.
    task automatic expectAt(input int offset, input string tag, input logic [1:0] ped,
                            input logic [3:0] car, input logic any_req);
        expect_t e;
        int idx;
        e.at      = cyc + offset;
        e.tag     = tag;
        e.ped     = ped;
        e.car     = car;
        e.any_req = any_req;
        idx = sb.size();
        for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].at > e.at) begin
                idx = k;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    always @(negedge clk) begin : monitor
        expect_t e;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            checkOutput({e.tag, "_ped"}, {6'b0, ped_request}, {6'b0, e.ped});
            checkOutput({e.tag, "_car"}, {4'b0, car_request}, {4'b0, e.car});
            checkOutput({e.tag, "_any"}, {7'b0, any_request}, {7'b0, e.any_req});
        end
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(2'b00, 4'b0000, 2'd1);
        waitCycles(3);
        expectAt(0, "reset", 2'b00, 4'b0000, 1'b0);
        waitCycles(1);

        // Button 0 pressed at reset release, served lane not active: set after 23 cycles.
        rst_n = 1'b1;
        applyStimulus(2'b01, 4'b0000, 2'd1);
        expectAt(22, "btn_pre", 2'b00, 4'b0000, 1'b0);
        expectAt(23, "btn_set", 2'b01, 4'b0000, 1'b1);
        waitCycles(26);

        // Asynchronous reset while held clears at once; debounce restarts from scratch.
        rst_n = 1'b0;
        expectAt(0, "rst_async", 2'b00, 4'b0000, 1'b0);
        waitCycles(3);
        rst_n = 1'b1;
        expectAt(1, "rst_rel", 2'b00, 4'b0000, 1'b0);
        expectAt(22, "rst_hold", 2'b00, 4'b0000, 1'b0);
        expectAt(23, "rst_reset", 2'b01, 4'b0000, 1'b1);
        waitCycles(26);

        // Phase 0 clears ped[0]; button still held does not re-request afterwards.
        applyStimulus(2'b01, 4'b0000, 2'd0);
        expectAt(1, "ped_clear", 2'b00, 4'b0000, 1'b0);
        waitCycles(5);
        applyStimulus(2'b01, 4'b0000, 2'd1);
        expectAt(1, "ped_norearm", 2'b00, 4'b0000, 1'b0);
        expectAt(10, "ped_norearm2", 2'b00, 4'b0000, 1'b0);
        waitCycles(10);
        applyStimulus(2'b00, 4'b0000, 2'd1);
        waitCycles(25);

        // 19-cycle glitch on sensor 2 is rejected.
        applyStimulus(2'b00, 4'b0100, 2'd0);
        expectAt(22, "glitch19", 2'b00, 4'b0000, 1'b0);
        expectAt(30, "glitch19b", 2'b00, 4'b0000, 1'b0);
        waitCycles(19);
        applyStimulus(2'b00, 4'b0000, 2'd0);
        waitCycles(15);

        // 20-cycle pulse on sensor 2 just passes the debouncer and latches.
        applyStimulus(2'b00, 4'b0100, 2'd0);
        expectAt(24, "pulse20_pre", 2'b00, 4'b0000, 1'b0);
        expectAt(25, "pulse20_set", 2'b00, 4'b0100, 1'b1);
        waitCycles(20);
        applyStimulus(2'b00, 4'b0000, 2'd0);
        waitCycles(10);
        applyStimulus(2'b00, 4'b0000, 2'd2);
        expectAt(1, "pulse20_clr", 2'b00, 4'b0000, 1'b0);
        waitCycles(20);
        applyStimulus(2'b00, 4'b0000, 2'd0);
        expectAt(5, "pulse20_idle", 2'b00, 4'b0000, 1'b0);
        waitCycles(5);

        // Held sensor 1 latches after 25 cycles; serving phase 1 clears it.
        applyStimulus(2'b00, 4'b0010, 2'd0);
        expectAt(24, "sens_pre", 2'b00, 4'b0000, 1'b0);
        expectAt(25, "sens_set", 2'b00, 4'b0010, 1'b1);
        waitCycles(26);
        applyStimulus(2'b00, 4'b0010, 2'd1);
        expectAt(1, "sens_clr", 2'b00, 4'b0000, 1'b0);
        waitCycles(3);
        applyStimulus(2'b00, 4'b0000, 2'd1);
        waitCycles(25);

        // Debounced edge of button 1 coincides with phase 2: clear wins.
        applyStimulus(2'b10, 4'b0000, 2'd1);
        waitCycles(22);
        applyStimulus(2'b10, 4'b0000, 2'd2);
        expectAt(1, "simul", 2'b00, 4'b0000, 1'b0);
        expectAt(2, "simul2", 2'b00, 4'b0000, 1'b0);
        waitCycles(4);
        applyStimulus(2'b10, 4'b0000, 2'd1);
        expectAt(1, "simul_after", 2'b00, 4'b0000, 1'b0);
        expectAt(5, "simul_after2", 2'b00, 4'b0000, 1'b0);
        waitCycles(6);
        applyStimulus(2'b00, 4'b0000, 2'd1);
        waitCycles(25);

        // Sensor 3 held through its own phase, then re-arms 3 cycles after leaving.
        applyStimulus(2'b00, 4'b1000, 2'd3);
        expectAt(25, "rearm_served", 2'b00, 4'b0000, 1'b0);
        expectAt(30, "rearm_served2", 2'b00, 4'b0000, 1'b0);
        waitCycles(30);
        applyStimulus(2'b00, 4'b1000, 2'd0);
        expectAt(2, "rearm_pre", 2'b00, 4'b0000, 1'b0);
        expectAt(3, "rearm_set", 2'b00, 4'b1000, 1'b1);
        waitCycles(5);
        applyStimulus(2'b00, 4'b1000, 2'd3);
        expectAt(1, "rearm_clr", 2'b00, 4'b0000, 1'b0);
        waitCycles(2);
        applyStimulus(2'b00, 4'b0000, 2'd3);
        waitCycles(25);

        for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clk);
        #1;
        checkOutput("sb_drain", 8'(sb.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
